// File: rtl/pixel_pkg.sv
// Shared constants and state encoding for the pixel column readout sequencer.
package pixel_pkg;

   localparam int WORDW = 30;
   localparam int DEPTH = 256;
   localparam int ADDRW = 8;
   localparam int CNTW  = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      READ = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/readout_obuf.sv
// One-entry valid/ready output register carrying data, source pixel and last flag.
module readout_obuf
   import pixel_pkg::*;
#(
   parameter int PIXW = 2
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   input  logic             load_i,
   input  logic [WORDW-1:0] data_i,
   input  logic [PIXW-1:0]  pix_i,
   input  logic             last_i,
   input  logic             ready_i,
   output logic             can_load_o,
   output logic             valid_o,
   output logic [WORDW-1:0] data_o,
   output logic [PIXW-1:0]  pix_o,
   output logic             last_o
);

   logic             valid_q, valid_d;
   logic [WORDW-1:0] data_q, data_d;
   logic [PIXW-1:0]  pix_q, pix_d;
   logic             last_q, last_d;

   // The slot is free when empty or when its current word leaves this cycle.
   assign can_load_o = !valid_q || ready_i;

   // Next-state of the output slot: a load replaces the word, a bare accept empties it.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      pix_d   = pix_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         pix_d   = pix_i;
         last_d  = last_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Output slot registers.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pix_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         pix_q   <= pix_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign pix_o   = pix_q;
   assign last_o  = last_q;

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Column sequencer: routes hits into per-pixel RAMs during acquisition and
// drains every non-empty pixel in order onto a valid/ready stream.
//
//   state | meaning
//   IDLE  | acquisition: accept hits, wait for start
//   SCAN  | test count of pixel p, one cycle per pixel
//   READ  | drive oe/addr of pixel p, stream its words
//   DONE  | wait for the final word to drain, then pulse done
module pixel_readout_ctrl
   import pixel_pkg::*;
#(
   parameter int NPIX = 4,
   parameter int PIXW = 2
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   input  logic             hit_valid_i,
   input  logic [PIXW-1:0]  hit_pix_i,
   input  logic [WORDW-1:0] hit_data_i,
   output logic             hit_ready_o,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [NPIX-1:0]  ovf_o,
   output logic [ADDRW-1:0] ram_addr_o,
   output logic [WORDW-1:0] ram_din_o,
   output logic [NPIX-1:0]  ram_we_o,
   output logic [NPIX-1:0]  ram_oe_o,
   input  logic [WORDW-1:0] ram_dout_i,
   output logic             out_valid_o,
   output logic [WORDW-1:0] out_data_o,
   output logic [PIXW-1:0]  out_pix_o,
   output logic             out_last_o,
   input  logic             out_ready_i
);

   localparam logic [NPIX-1:0] ONE   = NPIX'(1);
   localparam logic [PIXW-1:0] PLAST = PIXW'(NPIX - 1);

   state_e           state_q, state_d;
   logic [PIXW-1:0]  p_q, p_d;
   logic [ADDRW-1:0] rptr_q, rptr_d;
   logic [CNTW-1:0]  count_q [NPIX];
   logic [CNTW-1:0]  count_d [NPIX];
   logic [NPIX-1:0]  ovf_q, ovf_d;
   logic             done_q, done_d;

   logic             hit_fire;
   logic [CNTW-1:0]  hit_cnt;
   logic [CNTW-1:0]  cur_cnt;
   logic             rd_last;
   logic             obuf_load;
   logic             obuf_can_load;

   assign hit_ready_o = (state_q == IDLE) && reset_n_i;
   assign hit_fire    = hit_valid_i && hit_ready_o;
   assign hit_cnt     = count_q[hit_pix_i];
   assign cur_cnt     = count_q[p_q];
   // Count is never zero in READ, so the subtraction cannot wrap there.
   assign rd_last     = ({1'b0, rptr_q} == (cur_cnt - CNTW'(1)));

   // Next-state, counters and RAM bus drive; start is handled before the hit so
   // a hit dropped in the start cycle still leaves its overflow mark.
   always_comb begin
      state_d    = state_q;
      p_d        = p_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      ram_we_o   = '0;
      ram_oe_o   = '0;
      ram_addr_o = '0;
      ram_din_o  = '0;
      obuf_load  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               ovf_d   = '0;
               rptr_d  = '0;
               p_d     = '0;
               state_d = SCAN;
            end
            if (hit_fire) begin
               if (!hit_cnt[CNTW-1]) begin
                  ram_we_o           = ONE << hit_pix_i;
                  ram_addr_o         = hit_cnt[ADDRW-1:0];
                  ram_din_o          = hit_data_i;
                  count_d[hit_pix_i] = hit_cnt + CNTW'(1);
               end else begin
                  ovf_d[hit_pix_i] = 1'b1;
               end
            end
         end
         SCAN: begin
            if (cur_cnt != '0) begin
               state_d = READ;
            end else if (p_q == PLAST) begin
               state_d = DONE;
            end else begin
               p_d = p_q + PIXW'(1);
            end
         end
         READ: begin
            ram_oe_o   = ONE << p_q;
            ram_addr_o = rptr_q;
            if (obuf_can_load) begin
               obuf_load = 1'b1;
               rptr_d    = rptr_q + ADDRW'(1);
               if (rd_last) begin
                  count_d[p_q] = '0;
                  rptr_d       = '0;
                  if (p_q == PLAST) begin
                     state_d = DONE;
                  end else begin
                     p_d     = p_q + PIXW'(1);
                     state_d = SCAN;
                  end
               end
            end
         end
         DONE: begin
            if (obuf_can_load) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state, pointers, per-pixel counts and sticky overflow flags.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         p_q     <= '0;
         rptr_q  <= '0;
         ovf_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < NPIX; i++) begin
            count_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         rptr_q  <= rptr_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         for (int i = 0; i < NPIX; i++) begin
            count_q[i] <= count_d[i];
         end
      end
   end

   assign busy_o = (state_q != IDLE);
   assign done_o = done_q;
   assign ovf_o  = ovf_q;

   readout_obuf #(
      .PIXW (PIXW)
   ) u_obuf (
      .clock_i    (clock_i),
      .reset_n_i  (reset_n_i),
      .load_i     (obuf_load),
      .data_i     (ram_dout_i),
      .pix_i      (p_q),
      .last_i     (rd_last),
      .ready_i    (out_ready_i),
      .can_load_o (obuf_can_load),
      .valid_o    (out_valid_o),
      .data_o     (out_data_o),
      .pix_o      (out_pix_o),
      .last_o     (out_last_o)
   );

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Bench for pixel_readout_ctrl: behavioural pixel RAMs, a hit-vector table and
// directed readout sequences checked against a per-pixel queue model.
module tb_pixel_readout_ctrl;

   localparam int NPIX = 4;
   localparam int PIXW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            hit_valid;
   logic [PIXW-1:0] hit_pix;
   logic [29:0]     hit_data;
   logic            hit_ready;
   logic            start;
   logic            busy;
   logic            done;
   logic [NPIX-1:0] ovf;
   logic [7:0]      ram_addr;
   logic [29:0]     ram_din;
   logic [NPIX-1:0] ram_we;
   logic [NPIX-1:0] ram_oe;
   logic [29:0]     ram_dout;
   logic            out_valid;
   logic [29:0]     out_data;
   logic [PIXW-1:0] out_pix;
   logic            out_last;
   logic            out_ready;

   int errors = 0;
   int checks = 0;
   int inv_bad = 0;

   logic [29:0] mem [NPIX][256];
   logic [29:0] mq [NPIX][$];
   logic [32:0] exp_q [$];

   typedef struct {
      logic [PIXW-1:0] pix;
      logic [29:0]     data;
      logic [NPIX-1:0] exp_we;
      logic [7:0]      exp_addr;
   } hit_vec_t;

   hit_vec_t vecs [7];

   always #5 clk = ~clk;

   pixel_readout_ctrl #(.NPIX(NPIX), .PIXW(PIXW)) dut (
      .clock_i     (clk),
      .reset_n_i   (rst_n),
      .hit_valid_i (hit_valid),
      .hit_pix_i   (hit_pix),
      .hit_data_i  (hit_data),
      .hit_ready_o (hit_ready),
      .start_i     (start),
      .busy_o      (busy),
      .done_o      (done),
      .ovf_o       (ovf),
      .ram_addr_o  (ram_addr),
      .ram_din_o   (ram_din),
      .ram_we_o    (ram_we),
      .ram_oe_o    (ram_oe),
      .ram_dout_i  (ram_dout),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_pix_o   (out_pix),
      .out_last_o  (out_last),
      .out_ready_i (out_ready)
   );

   // Pixel RAMs: synchronous write, asynchronous read, shared bus selected by oe.
   always @(posedge clk) begin
      for (int i = 0; i < NPIX; i++)
         if (ram_we[i]) mem[i][ram_addr] <= ram_din;
   end

   always_comb begin
      ram_dout = '0;
      for (int i = 0; i < NPIX; i++)
         if (ram_oe[i]) ram_dout = mem[i][ram_addr];
   end

   // Bus invariants sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && (((ram_we != '0) && (ram_oe != '0)) || ($countones(ram_oe) > 1)))
         inv_bad++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic put_hit(input logic [PIXW-1:0] pix, input logic [29:0] d,
                          output logic [NPIX-1:0] we, output logic [7:0] addr,
                          output logic [29:0] din, output logic rdy);
      @(negedge clk);
      hit_valid = 1'b1;
      hit_pix   = pix;
      hit_data  = d;
      #1;
      we   = ram_we;
      addr = ram_addr;
      din  = ram_din;
      rdy  = hit_ready;
      @(posedge clk);
      if (rdy && mq[pix].size() < 256) mq[pix].push_back(d);
      #1;
      hit_valid = 1'b0;
   endtask

   // Start a readout and collect the stream; cycle 0 is the start cycle.
   task automatic readout(input int rmode, input bit hws, input logic [PIXW-1:0] hpix,
                          input logic [29:0] hdat, input bit hbusy,
                          output int first_v, output int done_c, output int busy_n,
                          output int nwords);
      int nexp;
      int bad;
      logic [32:0] w;
      first_v = -1;
      done_c  = -1;
      busy_n  = 0;
      nwords  = 0;
      bad     = 0;
      if (hws && mq[hpix].size() < 256) mq[hpix].push_back(hdat);
      exp_q.delete();
      for (int p = 0; p < NPIX; p++) begin
         for (int j = 0; j < mq[p].size(); j++)
            exp_q.push_back({1'(j == mq[p].size() - 1), PIXW'(p), mq[p][j]});
         mq[p].delete();
      end
      nexp = exp_q.size();
      @(negedge clk);
      start     = 1'b1;
      hit_valid = hws;
      hit_pix   = hpix;
      hit_data  = hdat;
      out_ready = 1'b1;
      @(posedge clk);
      for (int c = 1; c < 2000; c++) begin
         @(negedge clk);
         start     = 1'b0;
         hit_valid = hbusy && busy;
         hit_pix   = 2'd2;
         hit_data  = 30'h3FFF_FFFF;
         out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         if (c == 1) chk("ovf_cleared_at_start", 64'(ovf), 64'h0);
         if (busy) busy_n++;
         if (hit_valid && (hit_ready || ram_we != '0)) bad++;
         if (out_valid && first_v < 0) first_v = c;
         if (done) begin
            done_c = c;
            break;
         end
         if (out_valid && out_ready) begin
            nwords++;
            if (exp_q.size() == 0) begin
               chk("extra_word", 64'({out_last, out_pix, out_data}), 64'h1_FFFF_FFFF_F);
            end else begin
               w = exp_q.pop_front();
               chk("stream_word", 64'({out_last, out_pix, out_data}), 64'(w));
            end
         end
         @(posedge clk);
      end
      hit_valid = 1'b0;
      chk("done_seen", 64'(done_c >= 0), 64'h1);
      chk("word_count", 64'(nwords), 64'(nexp));
      if (hbusy) chk("no_hit_while_busy", 64'(bad), 64'h0);
   endtask

   initial begin
      logic [NPIX-1:0] we;
      logic [7:0]      addr;
      logic [29:0]     din;
      logic            rdy;
      int fv, dc, bn, nw;

      vecs[0] = '{2'd1, 30'h1,  4'b0010, 8'd0};
      vecs[1] = '{2'd1, 30'h2,  4'b0010, 8'd1};
      vecs[2] = '{2'd1, 30'h3,  4'b0010, 8'd2};
      vecs[3] = '{2'd0, 30'h0A, 4'b0001, 8'd0};
      vecs[4] = '{2'd2, 30'h2A, 4'b0100, 8'd0};
      vecs[5] = '{2'd0, 30'h0B, 4'b0001, 8'd1};
      vecs[6] = '{2'd2, 30'h2B, 4'b0100, 8'd1};

      rst_n = 1'b0; hit_valid = 1'b0; hit_pix = '0; hit_data = '0;
      start = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_outputs", 64'({busy, done, out_valid, out_last, hit_ready}), 64'h0);
      chk("rst_buses", 64'({out_data, out_pix, ram_addr, ram_din, ram_we, ram_oe, ovf}), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("hit_ready_after_rst", 64'(hit_ready), 64'h1);

      // Three hits to pixel 1, streamed with out_ready held high.
      for (int i = 0; i < 3; i++) begin
         put_hit(vecs[i].pix, vecs[i].data, we, addr, din, rdy);
         chk("vec_we", 64'(we), 64'(vecs[i].exp_we));
         chk("vec_addr", 64'(addr), 64'(vecs[i].exp_addr));
         chk("vec_din", 64'(din), 64'(vecs[i].data));
         chk("vec_ready", 64'(rdy), 64'h1);
      end
      readout(0, 1'b0, '0, '0, 1'b0, fv, dc, bn, nw);
      chk("t1_first_valid_cycle", 64'(fv), 64'd4);
      chk("t1_done_cycle", 64'(dc), 64'd9);
      put_hit(2'd1, 30'h77, we, addr, din, rdy);
      chk("t1_count_cleared_addr", 64'({we, addr}), 64'({4'b0010, 8'd0}));

      // Fill pixel 0 to capacity, then overflow it.
      for (int i = 0; i < 256; i++) begin
         put_hit(2'd0, 30'h100 + 30'(i), we, addr, din, rdy);
         chk("fill_addr", 64'({we, addr}), 64'({4'b0001, 8'(i)}));
      end
      put_hit(2'd0, 30'h3AB, we, addr, din, rdy);
      chk("full_drop_we", 64'(we), 64'h0);
      @(negedge clk);
      chk("ovf_set", 64'(ovf), 64'b0001);
      readout(0, 1'b0, '0, '0, 1'b0, fv, dc, bn, nw);
      chk("t2_words", 64'(nw), 64'd257);

      // Pixels 0 and 2, two words each, random backpressure.
      for (int i = 3; i < 7; i++) begin
         put_hit(vecs[i].pix, vecs[i].data, we, addr, din, rdy);
         chk("vec_we", 64'(we), 64'(vecs[i].exp_we));
         chk("vec_addr", 64'(addr), 64'(vecs[i].exp_addr));
      end
      readout(1, 1'b0, '0, '0, 1'b0, fv, dc, bn, nw);
      chk("t4_first_valid_cycle", 64'(fv), 64'd3);

      // Hit in the start cycle is read out; hits offered while busy are refused.
      readout(1, 1'b1, 2'd3, 30'h33, 1'b1, fv, dc, bn, nw);
      chk("t5_words", 64'(nw), 64'd1);
      chk("t5_ram_unchanged", 64'(mem[2][0]), 64'h2A);

      // Empty readout timing.
      readout(0, 1'b0, '0, '0, 1'b0, fv, dc, bn, nw);
      chk("empty_no_valid", 64'(fv), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("empty_done_cycle", 64'(dc), 64'd6);
      chk("empty_busy_cycles", 64'(bn), 64'd5);

      // Backpressure hold, then reset in the middle of READ.
      for (int i = 0; i < 3; i++) put_hit(2'd0, 30'h61 + 30'(i), we, addr, din, rdy);
      @(negedge clk); start = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); #1;
         if (c >= 3)
            chk("bp_hold", 64'({ram_oe, ram_addr, out_valid, out_data}),
                64'({4'b0001, 8'd1, 1'b1, 30'h61}));
      end
      rst_n = 1'b0;
      #1;
      chk("midread_rst", 64'({ram_oe, out_valid, busy, hit_ready, ovf}), 64'h0);
      for (int p = 0; p < NPIX; p++) mq[p].delete();
      @(negedge clk); rst_n = 1'b1;
      readout(0, 1'b0, '0, '0, 1'b0, fv, dc, bn, nw);
      chk("post_rst_no_words", 64'(nw), 64'd0);
      chk("post_rst_done_cycle", 64'(dc), 64'd6);

      chk("bus_invariants", 64'(inv_bad), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
